// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types for the LC-3b split I/D memory arbiter: word/mask types,
// arbiter state encoding and the IDLE grant rule.
package lc3b_mem_arbiter_pkg;

  localparam int unsigned LC3B_WORD_W  = 16;
  localparam int unsigned LC3B_WMASK_W = LC3B_WORD_W / 8;

  typedef logic [LC3B_WORD_W-1:0]  lc3b_word;
  typedef logic [LC3B_WMASK_W-1:0] lc3b_mem_wmask;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_I_ACC  = 3'd1,
    ARB_D_ACC  = 3'd2,
    ARB_I_RESP = 3'd3,
    ARB_D_RESP = 3'd4
  } lc3b_arb_state;

  // D wins unless both sides ask and the fetch side currently has precedence.
  function automatic logic arb_grant_d(input logic i_req,
                                       input logic d_req,
                                       input logic prefer_i);
    return d_req && !(i_req && prefer_i);
  endfunction

endpackage

// File: rtl/lc3b_mem_arbiter.sv
// Arbitrates pipeline I-fetch and D-access requests onto one physical memory port.
// Optional round-robin IDLE priority when LC3B_MEM_ARB_RR_EN is defined.
//
// state      | meaning
// ARB_IDLE   | no access in flight, grant on request
// ARB_I_ACC  | fetch issued to pmem, waiting for pmem_resp
// ARB_D_ACC  | load/store issued to pmem, waiting for pmem_resp
// ARB_I_RESP | one-cycle i_mem_resp with i_mem_rdata valid
// ARB_D_RESP | one-cycle d_mem_resp with d_mem_rdata valid
module lc3b_mem_arbiter
  import lc3b_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = LC3B_WORD_W,
  parameter int unsigned DATA_W = LC3B_WORD_W,
  parameter int unsigned BE_W   = LC3B_WMASK_W
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,

  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [DATA_W-1:0] d_mem_wdata,
  input  logic [BE_W-1:0]   d_mem_byte_enable,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  output logic [BE_W-1:0]   pmem_byte_enable,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  lc3b_arb_state     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              write_q, write_d;
  logic              abort_q, abort_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
`ifdef LC3B_MEM_ARB_RR_EN
  logic              rr_last_q, rr_last_d;   // 1: last serviced access was D
`endif

  logic i_req, d_req, prefer_i, grant_d;
  logic i_drop, d_drop, abort_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      write_q   <= 1'b0;
      abort_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef LC3B_MEM_ARB_RR_EN
      rr_last_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      write_q   <= write_d;
      abort_q   <= abort_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef LC3B_MEM_ARB_RR_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    write_d   = write_q;
    abort_d   = abort_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef LC3B_MEM_ARB_RR_EN
    rr_last_d = rr_last_q;
    prefer_i  = rr_last_q;
`else
    prefer_i  = 1'b0;
`endif

    i_req     = i_mem_read;
    d_req     = d_mem_read | d_mem_write;
    grant_d   = arb_grant_d(i_req, d_req, prefer_i);
    // A withdrawn or redirected request no longer wants the in-flight result.
    i_drop    = !i_req || (i_mem_address != addr_q);
    d_drop    = !d_req || (d_mem_address != addr_q);
    abort_now = abort_q;

    case (state_q)
      ARB_IDLE: begin
        abort_d = 1'b0;
        if (grant_d) begin
          addr_d  = d_mem_address;
          wdata_d = d_mem_wdata;
          be_d    = d_mem_byte_enable;
          write_d = d_mem_write;       // read+write together is treated as a write
          state_d = ARB_D_ACC;
        end else if (i_req) begin
          addr_d  = i_mem_address;
          write_d = 1'b0;
          state_d = ARB_I_ACC;
        end
      end

      ARB_I_ACC: begin
        abort_now = abort_q | i_drop;
        abort_d   = abort_now;
        if (pmem_resp) begin
          abort_d = 1'b0;
          if (abort_now) begin
            state_d = ARB_IDLE;
          end else begin
            i_rdata_d = pmem_rdata;
            state_d   = ARB_I_RESP;
`ifdef LC3B_MEM_ARB_RR_EN
            rr_last_d = 1'b0;
`endif
          end
        end
      end

      ARB_D_ACC: begin
        abort_now = abort_q | d_drop;
        abort_d   = abort_now;
        if (pmem_resp) begin
          abort_d = 1'b0;
          if (abort_now) begin
            state_d = ARB_IDLE;
          end else begin
            if (!write_q) d_rdata_d = pmem_rdata;
            state_d = ARB_D_RESP;
`ifdef LC3B_MEM_ARB_RR_EN
            rr_last_d = 1'b1;
`endif
          end
        end
      end

      ARB_I_RESP: state_d = ARB_IDLE;
      ARB_D_RESP: state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  assign pmem_read        = (state_q == ARB_I_ACC) || ((state_q == ARB_D_ACC) && !write_q);
  assign pmem_write       = (state_q == ARB_D_ACC) && write_q;
  assign pmem_address     = addr_q;
  assign pmem_wdata       = wdata_q;
  assign pmem_byte_enable = be_q;
  assign i_mem_resp       = (state_q == ARB_I_RESP);
  assign d_mem_resp       = (state_q == ARB_D_RESP);
  assign i_mem_rdata      = i_rdata_q;
  assign d_mem_rdata      = d_rdata_q;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter: directed latency/abort/reset cases
// plus randomized traffic against a word-level memory model.
module tb_lc3b_mem_arbiter;
  import lc3b_mem_arbiter_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_mem_read = 1'b0;
  lc3b_word      i_mem_address = '0;
  lc3b_word      i_mem_rdata;
  logic          i_mem_resp;
  logic          d_mem_read = 1'b0;
  logic          d_mem_write = 1'b0;
  lc3b_word      d_mem_address = '0;
  lc3b_word      d_mem_wdata = '0;
  lc3b_mem_wmask d_mem_byte_enable = '0;
  lc3b_word      d_mem_rdata;
  logic          d_mem_resp;
  logic          pmem_read, pmem_write;
  lc3b_word      pmem_address, pmem_wdata;
  lc3b_mem_wmask pmem_byte_enable;
  lc3b_word      pmem_rdata;
  logic          pmem_resp;

  logic     mem_auto = 1'b0;
  logic     man_resp = 1'b0;
  lc3b_word man_rdata = '0;
  logic     auto_resp = 1'b0;
  lc3b_word auto_rdata = '0;
  lc3b_word phys_mem [256];
  lc3b_word ref_mem  [256];

  int n_cmp = 0;
  int n_err = 0;

  assign pmem_resp  = mem_auto ? auto_resp  : man_resp;
  assign pmem_rdata = mem_auto ? auto_rdata : man_rdata;

  always #5 clk = ~clk;

  lc3b_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_byte_enable(d_mem_byte_enable),
    .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  function automatic lc3b_word init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b} ^ 16'h5A5A;
  endfunction

  // Physical memory with random 1..4 cycle latency, used in auto mode.
  initial begin
    int cnt;
    int lat;
    cnt = 0;
    lat = 1;
    for (int i = 0; i < 256; i++) phys_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (auto_resp) begin
        auto_resp = 1'b0;
        cnt = 0;
      end else if (mem_auto && (pmem_read || pmem_write)) begin
        if (cnt == 0) lat = $urandom_range(1, 4);
        cnt++;
        if (cnt >= lat) begin
          auto_resp = 1'b1;
          if (pmem_write) begin
            if (pmem_byte_enable[0]) phys_mem[pmem_address[7:0]][7:0]  = pmem_wdata[7:0];
            if (pmem_byte_enable[1]) phys_mem[pmem_address[7:0]][15:8] = pmem_wdata[15:8];
          end else begin
            auto_rdata = phys_mem[pmem_address[7:0]];
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_mem_read = 1'b0; i_mem_address = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0;
    d_mem_wdata = '0; d_mem_byte_enable = '0;
    man_resp = 1'b0; man_rdata = '0;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mem_auto = 1'b0;
    reset = 1'b1;
    idle_inputs();
    tick();
    n_cmp++;
    if ({pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
         i_mem_resp, d_mem_resp, i_mem_rdata, d_mem_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h ir=%b dr=%b, want all 0",
               pmem_read, pmem_write, pmem_address, i_mem_resp, d_mem_resp);
    end
    reset = 1'b0;
  endtask

  task automatic test_i_read();
    do_reset();
    i_mem_read = 1'b1; i_mem_address = 16'h3000;
    tick(); // cycle 1
    n_cmp++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h3000) begin
      n_err++;
      $display("FAIL iread_c1: rd=%b wr=%b addr=%h, want 1 0 3000", pmem_read, pmem_write, pmem_address);
    end
    tick(); // cycle 2
    n_cmp++;
    if (pmem_read !== 1'b1 || i_mem_resp !== 1'b0) begin
      n_err++;
      $display("FAIL iread_c2: rd=%b resp=%b, want 1 0", pmem_read, i_mem_resp);
    end
    man_resp = 1'b1; man_rdata = 16'h1234;
    tick(); // cycle 3
    man_resp = 1'b0;
    n_cmp++;
    if (i_mem_resp !== 1'b1 || i_mem_rdata !== 16'h1234 || pmem_read !== 1'b0) begin
      n_err++;
      $display("FAIL iread_c3: resp=%b rdata=%h rd=%b, want 1 1234 0", i_mem_resp, i_mem_rdata, pmem_read);
    end
    i_mem_read = 1'b0;
    tick(); // cycle 4
    n_cmp++;
    if (i_mem_resp !== 1'b0 || i_mem_rdata !== 16'h1234 || pmem_read !== 1'b0) begin
      n_err++;
      $display("FAIL iread_c4: resp=%b rdata=%h rd=%b, want 0 1234 0", i_mem_resp, i_mem_rdata, pmem_read);
    end
  endtask

  task automatic test_contention();
    do_reset();
    i_mem_read = 1'b1; i_mem_address = 16'h3000;
    d_mem_write = 1'b1; d_mem_address = 16'h4000;
    d_mem_wdata = 16'hBEEF; d_mem_byte_enable = 2'b01;
    tick(); // cycle 1
    n_cmp++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h4000 ||
        pmem_wdata !== 16'hBEEF || pmem_byte_enable !== 2'b01) begin
      n_err++;
      $display("FAIL contend_store: wr=%b rd=%b addr=%h wd=%h be=%b, want 1 0 4000 beef 01",
               pmem_write, pmem_read, pmem_address, pmem_wdata, pmem_byte_enable);
    end
    d_mem_wdata = 16'h0000; d_mem_byte_enable = 2'b10;
    tick(); // cycle 2
    n_cmp++;
    if (pmem_wdata !== 16'hBEEF || pmem_byte_enable !== 2'b01 || pmem_write !== 1'b1) begin
      n_err++;
      $display("FAIL contend_latched: wd=%h be=%b wr=%b, want beef 01 1", pmem_wdata, pmem_byte_enable, pmem_write);
    end
    man_resp = 1'b1;
    tick(); // cycle 3
    man_resp = 1'b0;
    n_cmp++;
    if (d_mem_resp !== 1'b1 || i_mem_resp !== 1'b0) begin
      n_err++;
      $display("FAIL contend_dresp: d=%b i=%b, want 1 0", d_mem_resp, i_mem_resp);
    end
    d_mem_write = 1'b0;
    tick(); // cycle 4 idle
    n_cmp++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || d_mem_resp !== 1'b0) begin
      n_err++;
      $display("FAIL contend_idle: rd=%b wr=%b d=%b, want 0 0 0", pmem_read, pmem_write, d_mem_resp);
    end
    tick(); // cycle 5
    n_cmp++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h3000) begin
      n_err++;
      $display("FAIL contend_fetch: rd=%b addr=%h, want 1 3000", pmem_read, pmem_address);
    end
    man_resp = 1'b1; man_rdata = 16'hCAFE;
    tick(); // cycle 6
    man_resp = 1'b0;
    n_cmp++;
    if (i_mem_resp !== 1'b1 || i_mem_rdata !== 16'hCAFE) begin
      n_err++;
      $display("FAIL contend_iresp: resp=%b rdata=%h, want 1 cafe", i_mem_resp, i_mem_rdata);
    end
    i_mem_read = 1'b0;
    tick();
  endtask

  task automatic test_i_abort();
    do_reset();
    i_mem_read = 1'b1; i_mem_address = 16'h3000;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) i_mem_read = 1'b0;
      n_cmp++;
      if (pmem_read !== 1'b1 || i_mem_resp !== 1'b0) begin
        n_err++;
        $display("FAIL iabort_hold c%0d: rd=%b resp=%b, want 1 0", c, pmem_read, i_mem_resp);
      end
      if (c == 4) begin
        man_resp = 1'b1; man_rdata = 16'hDEAD;
      end
    end
    tick(); // cycle 5
    man_resp = 1'b0;
    n_cmp++;
    if (i_mem_resp !== 1'b0 || pmem_read !== 1'b0 || i_mem_rdata !== 16'h0000) begin
      n_err++;
      $display("FAIL iabort_noresp: resp=%b rd=%b rdata=%h, want 0 0 0000", i_mem_resp, pmem_read, i_mem_rdata);
    end
    i_mem_read = 1'b1; i_mem_address = 16'h3002;
    tick(); // cycle 6: back in an access, proving IDLE was reached
    n_cmp++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h3002) begin
      n_err++;
      $display("FAIL iabort_regrant: rd=%b addr=%h, want 1 3002", pmem_read, pmem_address);
    end
    man_resp = 1'b1; man_rdata = 16'h0102;
    tick();
    man_resp = 1'b0;
    n_cmp++;
    if (i_mem_resp !== 1'b1 || i_mem_rdata !== 16'h0102) begin
      n_err++;
      $display("FAIL iabort_next: resp=%b rdata=%h, want 1 0102", i_mem_resp, i_mem_rdata);
    end
    i_mem_read = 1'b0;
  endtask

  task automatic test_addr_change();
    do_reset();
    i_mem_read = 1'b1; i_mem_address = 16'h3000;
    tick(); // cycle 1
    tick(); // cycle 2
    i_mem_address = 16'h3010;
    tick(); // cycle 3
    man_resp = 1'b1; man_rdata = 16'hAAAA;
    tick(); // cycle 4
    man_resp = 1'b0;
    n_cmp++;
    if (i_mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
      n_err++;
      $display("FAIL redirect_discard: resp=%b rd=%b, want 0 0", i_mem_resp, pmem_read);
    end
    tick(); // cycle 5
    n_cmp++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h3010) begin
      n_err++;
      $display("FAIL redirect_reissue: rd=%b addr=%h, want 1 3010", pmem_read, pmem_address);
    end
    man_resp = 1'b1; man_rdata = 16'h5555;
    tick(); // cycle 6
    man_resp = 1'b0;
    n_cmp++;
    if (i_mem_resp !== 1'b1 || i_mem_rdata !== 16'h5555) begin
      n_err++;
      $display("FAIL redirect_resp: resp=%b rdata=%h, want 1 5555", i_mem_resp, i_mem_rdata);
    end
    i_mem_read = 1'b0;
  endtask

  task automatic test_d_abort();
    do_reset();
    d_mem_write = 1'b1; d_mem_address = 16'h4010; d_mem_wdata = 16'h7777; d_mem_byte_enable = 2'b11;
    tick(); // cycle 1
    d_mem_write = 1'b0;
    tick(); // cycle 2
    n_cmp++;
    if (pmem_write !== 1'b1 || d_mem_resp !== 1'b0) begin
      n_err++;
      $display("FAIL dabort_hold: wr=%b resp=%b, want 1 0", pmem_write, d_mem_resp);
    end
    man_resp = 1'b1;
    tick(); // cycle 3
    man_resp = 1'b0;
    n_cmp++;
    if (d_mem_resp !== 1'b0 || pmem_write !== 1'b0) begin
      n_err++;
      $display("FAIL dabort_noresp: resp=%b wr=%b, want 0 0", d_mem_resp, pmem_write);
    end
  endtask

  task automatic test_illegal_rw();
    do_reset();
    d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_address = 16'h4006;
    d_mem_wdata = 16'h1111; d_mem_byte_enable = 2'b11;
    tick();
    n_cmp++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_rw: wr=%b rd=%b, want 1 0", pmem_write, pmem_read);
    end
    man_resp = 1'b1;
    tick();
    man_resp = 1'b0;
    d_mem_read = 1'b0; d_mem_write = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_mem_read = 1'b1; d_mem_address = 16'h4002;
    tick(); // cycle 1, D_ACC
    n_cmp++;
    if (pmem_read !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_acc: rd=%b, want 1", pmem_read);
    end
    reset = 1'b1; d_mem_read = 1'b0;
    tick();
    reset = 1'b0;
    man_resp = 1'b1; man_rdata = 16'h9999;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if ({pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
           i_mem_resp, d_mem_resp, i_mem_rdata, d_mem_rdata} !== '0) begin
        n_err++;
        $display("FAIL rstmid_zero c%0d: rd=%b wr=%b addr=%h dresp=%b drdata=%h, want all 0",
                 c, pmem_read, pmem_write, pmem_address, d_mem_resp, d_mem_rdata);
      end
      tick();
      man_resp = 1'b0;
    end
  endtask

  task automatic test_rr();
    logic exp_d [4];
    logic got_d [4];
    int   n;
`ifdef LC3B_MEM_ARB_RR_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    mem_auto = 1'b1;
    n = 0;
    i_mem_read = 1'b1; i_mem_address = 16'h3011;
    d_mem_read = 1'b1; d_mem_address = 16'h3022;
    for (int c = 0; c < 80 && n < 4; c++) begin
      tick();
      if (i_mem_resp) begin got_d[n] = 1'b0; n++; end
      else if (d_mem_resp) begin got_d[n] = 1'b1; n++; end
    end
    i_mem_read = 1'b0; d_mem_read = 1'b0;
    n_cmp++;
    if (n != 4) begin
      n_err++;
      $display("FAIL rr_timeout: got %0d grants, want 4", n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (got_d[k] !== exp_d[k]) begin
          n_err++;
          $display("FAIL rr_order[%0d]: got %s, want %s", k, got_d[k] ? "D" : "I", exp_d[k] ? "D" : "I");
        end
      end
    end
    tick();
    mem_auto = 1'b0;
  endtask

  task automatic test_random();
    logic     last_d;
    int       kind;
    logic     pend_i, pend_d, is_wr, first_seen, exp_first_d, done;
    lc3b_word ia, da, wd, exp_w;
    lc3b_mem_wmask be;
    do_reset();
    mem_auto = 1'b1;
    last_d = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int t = 0; t < 60; t++) begin
      kind  = $urandom_range(0, 2);
      ia    = {8'h30, 8'($urandom_range(0, 15))};
      da    = {8'h30, 8'($urandom_range(0, 15))};
      wd    = 16'($urandom);
      be    = 2'($urandom);
      is_wr = 1'($urandom);
      pend_i = (kind != 1);
      pend_d = (kind != 0);
`ifdef LC3B_MEM_ARB_RR_EN
      exp_first_d = !last_d;
`else
      exp_first_d = 1'b1;
`endif
      i_mem_read = pend_i; i_mem_address = ia;
      d_mem_read = pend_d && !is_wr; d_mem_write = pend_d && is_wr;
      d_mem_address = da; d_mem_wdata = wd; d_mem_byte_enable = be;
      first_seen = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        tick();
        n_cmp++;
        if ((pmem_read && pmem_write) || (i_mem_resp && d_mem_resp)) begin
          n_err++;
          $display("FAIL rnd_excl t%0d: rd=%b wr=%b iresp=%b dresp=%b", t, pmem_read, pmem_write, i_mem_resp, d_mem_resp);
        end
        if (i_mem_resp || d_mem_resp) begin
          if (kind == 2 && !first_seen) begin
            n_cmp++;
            if (d_mem_resp !== exp_first_d) begin
              n_err++;
              $display("FAIL rnd_order t%0d: first=%s want %s", t, d_mem_resp ? "D" : "I", exp_first_d ? "D" : "I");
            end
          end
          first_seen = 1'b1;
        end
        if (i_mem_resp) begin
          n_cmp++;
          if (!pend_i || i_mem_rdata !== ref_mem[ia[7:0]]) begin
            n_err++;
            $display("FAIL rnd_fetch t%0d: pend=%b rdata=%h want %h", t, pend_i, i_mem_rdata, ref_mem[ia[7:0]]);
          end
          pend_i = 1'b0; i_mem_read = 1'b0; last_d = 1'b0;
        end
        if (d_mem_resp) begin
          if (is_wr) begin
            exp_w = ref_mem[da[7:0]];
            if (be[0]) exp_w[7:0]  = wd[7:0];
            if (be[1]) exp_w[15:8] = wd[15:8];
            ref_mem[da[7:0]] = exp_w;
          end else begin
            n_cmp++;
            if (!pend_d || d_mem_rdata !== ref_mem[da[7:0]]) begin
              n_err++;
              $display("FAIL rnd_load t%0d: pend=%b rdata=%h want %h", t, pend_d, d_mem_rdata, ref_mem[da[7:0]]);
            end
          end
          pend_d = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0; last_d = 1'b1;
        end
        done = !pend_i && !pend_d;
      end
      if (!done) begin
        n_cmp++;
        n_err++;
        $display("FAIL rnd_timeout t%0d: pend_i=%b pend_d=%b", t, pend_i, pend_d);
        do_reset();
        last_d = 1'b0;
      end
    end
    // Read back every touched word so lost or mis-masked stores show up.
    for (int a = 0; a < 16; a++) begin
      i_mem_read = 1'b1; i_mem_address = {8'h30, 8'(a)};
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        tick();
        if (i_mem_resp) begin
          n_cmp++;
          if (i_mem_rdata !== ref_mem[a]) begin
            n_err++;
            $display("FAIL rnd_readback a%0d: rdata=%h want %h", a, i_mem_rdata, ref_mem[a]);
          end
          i_mem_read = 1'b0;
          done = 1'b1;
        end
      end
      if (!done) begin
        n_cmp++;
        n_err++;
        $display("FAIL rnd_readback_timeout a%0d", a);
        i_mem_read = 1'b0;
      end
    end
    tick();
    mem_auto = 1'b0;
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_contention();
    test_i_abort();
    test_addr_change();
    test_d_abort();
    test_illegal_rw();
    test_reset_mid();
    test_rr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
